// File: rtl/alu_mmio_ctrl.sv
// alu_mmio_ctrl: bus-mapped register front end that sequences the external 16-bit ALU.
// Optional feature macro ALU_MMIO_CTRL_IRQ_EN enables CTRL.irq_en and the irq output.
module alu_mmio_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] bus_addr,
   input  logic                  bus_wr_en,
   input  logic                  bus_rd_en,
   input  logic [DATA_WIDTH-1:0] bus_wdata,
   output logic [DATA_WIDTH-1:0] bus_rdata,
   output logic                  bus_ready,
   output logic                  irq,
   output logic [DATA_WIDTH-1:0] alu_a_in,
   output logic [DATA_WIDTH-1:0] alu_b_in,
   output logic [DATA_WIDTH-1:0] alu_op,
   input  logic [DATA_WIDTH-1:0] alu_dout,
   input  logic [DATA_WIDTH-1:0] alu_flags
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_A      = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_B      = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_OP     = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] ADDR_RESULT = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] ADDR_FLAGS  = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(5);
   localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(6);
   localparam logic [DATA_WIDTH-1:0] OP_MAX      = DATA_WIDTH'(8);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_CAPT
   } state_t;

   state_t state_reg, state_next;

   logic [DATA_WIDTH-1:0] a_reg;
   logic [DATA_WIDTH-1:0] b_reg;
   logic [DATA_WIDTH-1:0] op_reg;
   logic [DATA_WIDTH-1:0] result_reg;
   logic [2:0]            flags_reg;
   logic                  done_reg;
   logic                  err_reg;
   logic                  irq_en_bit;

   logic busy;
   logic operand_addr;
   logic wr_commit;
   logic op_write;
   logic op_valid;
   logic op_start;
   logic ctrl_write;
   logic ctrl_clear;
   logic capture;

   assign busy         = (state_reg != ST_IDLE);
   assign operand_addr = (bus_addr <= ADDR_OP);

   // Operand/opcode writes stall for the whole operation so the ALU inputs stay stable.
   assign bus_ready    = !rst && !(bus_wr_en && operand_addr && busy);
   assign wr_commit    = bus_wr_en && bus_ready;
   assign op_write     = wr_commit && (bus_addr == ADDR_OP);
   assign op_valid     = (bus_wdata <= OP_MAX);
   assign op_start     = op_write && op_valid;
   assign ctrl_write   = wr_commit && (bus_addr == ADDR_CTRL);
   assign ctrl_clear   = ctrl_write && bus_wdata[1];
   assign capture      = (state_reg == ST_CAPT);

   assign alu_a_in = a_reg;
   assign alu_b_in = b_reg;
   assign alu_op   = op_reg;

   // Only the low three flag bits carry meaning.
   logic unused_flags;
   assign unused_flags = &{1'b0, alu_flags[DATA_WIDTH-1:3]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (op_start) state_next = ST_EXEC;
         ST_EXEC: state_next = ST_CAPT;
         ST_CAPT: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= '0;
         result_reg <= '0;
         flags_reg  <= '0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         if (wr_commit && bus_addr == ADDR_A) a_reg <= bus_wdata;
         if (wr_commit && bus_addr == ADDR_B) b_reg <= bus_wdata;
         if (op_write) op_reg <= bus_wdata;

         if (capture) begin
            result_reg <= alu_dout;
            flags_reg  <= alu_flags[2:0];
         end

         // Capture outranks a simultaneous software clear.
         if (capture) begin
            done_reg <= 1'b1;
         end else if (op_start || ctrl_clear) begin
            done_reg <= 1'b0;
         end

         if (op_write) begin
            err_reg <= !op_valid;
         end else if (ctrl_clear) begin
            err_reg <= 1'b0;
         end
      end
   end

`ifdef ALU_MMIO_CTRL_IRQ_EN
   logic irq_en_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_en_reg <= 1'b0;
      end else if (ctrl_write) begin
         irq_en_reg <= bus_wdata[0];
      end
   end

   assign irq_en_bit = irq_en_reg;
   assign irq        = done_reg & irq_en_reg;
`else
   assign irq_en_bit = 1'b0;
   assign irq        = 1'b0;
`endif

   // A combined read/write cycle returns zero so the read cannot observe a half-written value.
   always_comb begin
      bus_rdata = '0;
      if (!(bus_wr_en && bus_rd_en)) begin
         case (bus_addr)
            ADDR_A:      bus_rdata = a_reg;
            ADDR_B:      bus_rdata = b_reg;
            ADDR_OP:     bus_rdata = op_reg;
            ADDR_RESULT: bus_rdata = result_reg;
            ADDR_FLAGS:  bus_rdata = {{(DATA_WIDTH-3){1'b0}}, flags_reg};
            ADDR_STATUS: bus_rdata = {{(DATA_WIDTH-3){1'b0}}, err_reg, done_reg, busy};
            ADDR_CTRL:   bus_rdata = {{(DATA_WIDTH-1){1'b0}}, irq_en_bit};
            default:     bus_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mmio_ctrl.sv
// tb_alu_mmio_ctrl: directed and randomized bus traffic checked against a cycle-count
// reference model of the register file and operation timeline.
module tb_alu_mmio_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  bus_addr = '0;
   logic        bus_wr_en = 1'b0;
   logic        bus_rd_en = 1'b0;
   logic [15:0] bus_wdata = '0;
   logic [15:0] bus_rdata;
   logic        bus_ready;
   logic        irq;
   logic [15:0] alu_a_in, alu_b_in, alu_op;
   logic [15:0] alu_dout, alu_flags;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_mmio_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
      .clk(clk), .rst(rst),
      .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_rd_en(bus_rd_en),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
      .irq(irq),
      .alu_a_in(alu_a_in), .alu_b_in(alu_b_in), .alu_op(alu_op),
      .alu_dout(alu_dout), .alu_flags(alu_flags)
   );

   // Behavioural ALU: returns {c, n, z, result}.
   function automatic logic [18:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] op);
      logic [16:0] wide;
      logic [15:0] r;
      logic        c;
      c = 1'b0;
      case (op)
         16'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[15:0]; c = wide[16]; end
         16'd1: begin r = a - b; c = (a < b); end
         16'd2: r = a >> b[3:0];
         16'd3: r = a << b[3:0];
         16'd4: r = a | b;
         16'd5: r = ~(a | b);
         16'd6: r = a & b;
         16'd7: r = ~(a & b);
         16'd8: r = a ^ b;
         default: r = 16'h0;
      endcase
      return {c, r[15], (r == 16'h0), r};
   endfunction

   logic [18:0] alu_now;
   assign alu_now   = alu_ref(alu_a_in, alu_b_in, alu_op);
   assign alu_dout  = alu_now[15:0];
   assign alu_flags = {13'h1ACE, alu_now[18:16]};

   // Reference model state.
   logic [15:0] m_a, m_b, m_op, m_result;
   logic [2:0]  m_flags;
   logic        m_done, m_err, m_irq_en;
   bit          pend_valid;
   int          pend_edge;
   int          done_set_edge;
   logic [18:0] pend_res;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_a = '0; m_b = '0; m_op = '0; m_result = '0; m_flags = '0;
      m_done = 1'b0; m_err = 1'b0; m_irq_en = 1'b0;
      pend_valid = 1'b0; pend_edge = -100; done_set_edge = -100; pend_res = '0;
   endtask

   // An operation committed at edge N lands its result at edge N+2.
   task automatic settle();
      if (pend_valid && cyc >= pend_edge + 2) begin
         m_result      = pend_res[15:0];
         m_flags       = pend_res[18:16];
         m_done        = 1'b1;
         done_set_edge = pend_edge + 2;
         pend_valid    = 1'b0;
      end
   endtask

   task automatic model_write(input logic [2:0] ad, input logic [15:0] d, input int e);
      settle();
      case (ad)
         3'd0: m_a = d;
         3'd1: m_b = d;
         3'd2: begin
            m_op = d;
            if (d > 16'd8) begin
               m_err = 1'b1;
            end else begin
               m_err = 1'b0;
               m_done = 1'b0;
               pend_valid = 1'b1;
               pend_edge = e;
               pend_res = alu_ref(m_a, m_b, d);
            end
         end
         3'd6: begin
`ifdef ALU_MMIO_CTRL_IRQ_EN
            m_irq_en = d[0];
`endif
            if (d[1]) begin
               m_err = 1'b0;
               if (done_set_edge != e) m_done = 1'b0;
            end
         end
         default: ;
      endcase
   endtask

   function automatic logic [15:0] exp_reg(input logic [2:0] ad);
      case (ad)
         3'd0: return m_a;
         3'd1: return m_b;
         3'd2: return m_op;
         3'd3: return m_result;
         3'd4: return {13'h0, m_flags};
         3'd5: return {13'h0, m_err, m_done, pend_valid};
         3'd6: return {15'h0, m_irq_en};
         default: return 16'h0;
      endcase
   endfunction

   function automatic logic exp_irq();
`ifdef ALU_MMIO_CTRL_IRQ_EN
      return m_done & m_irq_en;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_outs();
      settle();
      check("alu_a_in", 32'(alu_a_in), 32'(m_a));
      check("alu_b_in", 32'(alu_b_in), 32'(m_b));
      check("alu_op", 32'(alu_op), 32'(m_op));
      check("irq", 32'(irq), 32'(exp_irq()));
   endtask

   task automatic do_write(input logic [2:0] ad, input logic [15:0] d, input bit both,
                           output int stalls);
      int first_edge;
      int exp_stalls;
      @(negedge clk);
      settle();
      first_edge = cyc + 1;
      exp_stalls = 0;
      if (ad <= 3'd2 && pend_valid && pend_edge + 3 > first_edge)
         exp_stalls = pend_edge + 3 - first_edge;
      bus_addr = ad; bus_wdata = d; bus_wr_en = 1'b1; bus_rd_en = both;
      stalls = 0;
      #1;
      if (both) check("rdata_wr_rd", 32'(bus_rdata), 32'h0);
      while (!bus_ready && stalls < 10) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      bus_wr_en = 1'b0; bus_rd_en = 1'b0;
      model_write(ad, d, cyc);
      check("stalls", 32'(stalls), 32'(exp_stalls));
      check_outs();
      $display("wr addr=%0d data=%h both=%0d stalls=%0d edge=%0d", ad, d, both, stalls, cyc);
   endtask

   task automatic do_read(input logic [2:0] ad, output logic [15:0] v);
      @(negedge clk);
      settle();
      bus_addr = ad; bus_rd_en = 1'b1;
      #1;
      v = bus_rdata;
      check($sformatf("read_%0d", ad), 32'(v), 32'(exp_reg(ad)));
      check("read_ready", 32'(bus_ready), rst ? 32'h0 : 32'h1);
      bus_rd_en = 1'b0;
      check_outs();
      $display("rd addr=%0d data=%h cycle=%0d", ad, v, cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [15:0] v;
   int          st;

   initial begin
      model_reset();

      // Power-on reset: everything reads zero.
      for (int i = 0; i < 8; i++) do_read(3'(i), v);
      check("reset_ready", 32'(bus_ready), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of an ADD.
      do_write(3'd0, 16'd5, 1'b0, st);
      do_write(3'd1, 16'd3, 1'b0, st);
      do_write(3'd2, 16'd0, 1'b0, st);
      rst = 1'b1;
      #1;
      model_reset();
      check("midop_a", 32'(alu_a_in), 32'h0);
      check("midop_op", 32'(alu_op), 32'h0);
      check("midop_ready", 32'(bus_ready), 32'h0);
      for (int i = 0; i < 8; i++) do_read(3'(i), v);
      do_read(3'd5, v);
      check("midop_status", 32'(v), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(3);
      do_read(3'd3, v);
      check("midop_result", 32'(v), 32'h0);

      // ADD with carry out.
      do_write(3'd0, 16'hFFFF, 1'b0, st);
      do_write(3'd1, 16'h0001, 1'b0, st);
      do_write(3'd2, 16'd0, 1'b0, st);
      do_read(3'd5, v);
      check("add_busy", 32'(v[0]), 32'h1);
      idle(1);
      do_read(3'd3, v);
      check("add_result", 32'(v), 32'h0000);
      do_read(3'd4, v);
      check("add_flags", 32'(v), 32'h0005);
      do_read(3'd5, v);
      check("add_status", 32'(v), 32'h0002);

      // Operand write stalls behind a SUB.
      do_write(3'd0, 16'h0010, 1'b0, st);
      do_write(3'd1, 16'h0001, 1'b0, st);
      do_write(3'd2, 16'd1, 1'b0, st);
      do_write(3'd1, 16'h0002, 1'b0, st);
      check("stall_count", 32'(st), 32'h2);
      do_read(3'd3, v);
      check("sub_result", 32'(v), 32'h000F);
      do_read(3'd1, v);
      check("sub_b", 32'(v), 32'h0002);

      // Invalid opcode.
      do_write(3'd6, 16'h0002, 1'b0, st);
      do_write(3'd2, 16'd9, 1'b0, st);
      do_read(3'd5, v);
      check("inv_status", 32'(v), 32'h0004);
      do_read(3'd3, v);
      check("inv_result", 32'(v), 32'h000F);
      do_write(3'd6, 16'h0002, 1'b0, st);
      do_read(3'd5, v);
      check("inv_clear", 32'(v), 32'h0000);

      // Done interrupt.
      do_write(3'd6, 16'h0001, 1'b0, st);
      do_write(3'd0, 16'h00F0, 1'b0, st);
      do_write(3'd1, 16'h0F00, 1'b0, st);
      do_write(3'd2, 16'd4, 1'b0, st);
      idle(2);
      do_read(3'd3, v);
      check("or_result", 32'(v), 32'h0FF0);
`ifdef ALU_MMIO_CTRL_IRQ_EN
      check("irq_set", 32'(irq), 32'h1);
`else
      check("irq_tied", 32'(irq), 32'h0);
      do_read(3'd6, v);
      check("ctrl_reads0", 32'(v), 32'h0);
`endif
      do_write(3'd6, 16'h0003, 1'b0, st);
      check("irq_clear", 32'(irq), 32'h0);

      // CTRL clear landing on the capture edge: done stays set.
      do_write(3'd2, 16'd8, 1'b0, st);
      @(negedge clk);
      do_write(3'd6, 16'h0002, 1'b0, st);
      do_read(3'd5, v);
      check("setclr_status", 32'(v), 32'h0002);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         int kind;
         logic [2:0]  ad;
         logic [15:0] d;
         kind = $urandom_range(0, 9);
         ad = 3'($urandom_range(0, 7));
         if (kind < 4) begin
            do_read(ad, v);
         end else begin
            d = 16'($urandom);
            if (ad == 3'd2)
               d = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 10));
            if (ad == 3'd6 && $urandom_range(0, 1) == 0) d = d & 16'h0001;
            do_write(ad, d, ($urandom_range(0, 7) == 0), st);
         end
         idle($urandom_range(0, 2));
      end
      for (int i = 0; i < 8; i++) do_read(3'(i), v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
